k007452_divider: RTL

K007452_DIVIDER -- requirements
Module: k007452_divider

---
 rtl/k007452_divider.sv | 109 ++++++++++
 1 files changed

// File: rtl/k007452_divider.sv
// Unsigned 16/16 restoring divider: one quotient bit per clock, MSB first,
// with a fixed start-to-DONE latency and a saturated result for divide-by-zero.
module k007452_divider (
  input  logic        CLK,
  input  logic        RES,
  input  logic        START,
  input  logic [15:0] DIVIDEND,
  input  logic [15:0] DIVISOR,
  output logic [15:0] QUOT,
  output logic [15:0] REM,
  output logic        BUSY,
  output logic        DONE
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] part_rem;
  logic [15:0] shift_q;
  logic [15:0] dvsr;
  logic [3:0]  count;
  logic        load;
  logic        step;
  logic        finish;
  logic [16:0] shifted;
  logic [16:0] trial;
  logic        trial_ok;

  // Because the partial remainder is always below the divisor, the shifted value
  // is under 2*divisor, so bit 16 of the 17-bit difference is its sign.
  always_comb begin
    shifted  = {part_rem, shift_q[15]};
    trial    = shifted - {1'b0, dvsr};
    trial_ok = ~trial[16];
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (START) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (START) begin
          load = 1'b1;
        end else begin
          step = 1'b1;
          if (count == 4'd0) state_nxt = FIN;
        end
      end
      FIN: begin
        finish = 1'b1;
        if (START) begin
          load      = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A restart in FIN publishes the finishing result from the old operands
  // while the same edge latches the new ones.
  always_ff @(posedge CLK) begin
    if (RES) begin
      state    <= IDLE;
      part_rem <= 16'h0000;
      shift_q  <= 16'h0000;
      dvsr     <= 16'h0000;
      count    <= 4'd0;
      QUOT     <= 16'h0000;
      REM      <= 16'h0000;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
    end else begin
      state <= state_nxt;
      BUSY  <= (state_nxt != IDLE);
      DONE  <= finish;
      if (load) begin
        dvsr     <= DIVISOR;
        shift_q  <= DIVIDEND;
        part_rem <= 16'h0000;
        count    <= 4'd15;
      end else if (step) begin
        part_rem <= trial_ok ? trial[15:0] : shifted[15:0];
        shift_q  <= {shift_q[14:0], trial_ok};
        count    <= count - 4'd1;
      end
      if (finish) begin
        QUOT <= (dvsr == 16'h0000) ? 16'hFFFF : shift_q;
        REM  <= (dvsr == 16'h0000) ? 16'h0000 : part_rem;
      end
    end
  end

endmodule
